// File: rtl/mdio_pkg.sv
// Shared frame constants, field widths and FSM states for the Clause 22/45 MDIO master.
package mdio_pkg;

  localparam logic [1:0] ST_C22      = 2'b01;
  localparam logic [1:0] ST_C45      = 2'b00;
  localparam logic [1:0] OP22_WR     = 2'b01;
  localparam logic [1:0] OP22_RD     = 2'b10;
  localparam logic [1:0] OP45_ADDR   = 2'b00;
  localparam logic [1:0] OP45_WR     = 2'b01;
  localparam logic [1:0] OP45_RD     = 2'b11;
  localparam logic [1:0] OP45_RDINC  = 2'b10;

  localparam int PA_W   = 5;
  localparam int RA_W   = 5;
  localparam int TA_W   = 2;
  localparam int DATA_W = 16;
  localparam int HDR_W  = 14;

  localparam logic [TA_W-1:0] TA_WR = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_e;

  function automatic logic legal_op(input logic c45, input logic [1:0] op);
    return c45 ? (op inside {OP45_ADDR, OP45_WR, OP45_RD, OP45_RDINC})
               : (op inside {OP22_WR, OP22_RD});
  endfunction

  function automatic logic is_read(input logic c45, input logic [1:0] op);
    return c45 ? (op == OP45_RD || op == OP45_RDINC) : (op == OP22_RD);
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: CLK_DIV cycles low then CLK_DIV high, restartable so a frame starts on a clean low phase.
module mdio_clk_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic mdc_lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] C_RISE = CW'(CLK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || cnt_q == C_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // rise_o marks the first high cycle; fall_o the last cycle before MDC drops (bit boundary)
  assign mdc_lvl_o = (cnt_q >= C_RISE);
  assign rise_o    = (cnt_q == C_RISE);
  assign fall_o    = (cnt_q == C_LAST);

endmodule

// File: rtl/mdio_master_c45.sv
// MDIO management master: one Clause 22/45 frame at a time on one of NR_BUS buses.
module mdio_master_c45
  import mdio_pkg::*;
#(
  parameter int NR_BUS   = 4,
  parameter int CLK_DIV  = 5,
  parameter int PREAMBLE = 32,
  parameter bit C45_EN   = 1'b1,
  localparam int BW = (NR_BUS > 1) ? $clog2(NR_BUS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BW-1:0]     s_bus,
  input  logic              s_c45,
  input  logic [1:0]        s_op,
  input  logic [PA_W-1:0]   s_pa,
  input  logic [RA_W-1:0]   s_ra,
  input  logic [DATA_W-1:0] s_d,
  input  logic              s_dv,
  output logic              s_dr,
  output logic [DATA_W-1:0] m_d,
  output logic              m_dv,
  output logic              m_err,
  output logic [NR_BUS-1:0] mdc,
  output logic [NR_BUS-1:0] mdio_o,
  output logic [NR_BUS-1:0] mdio_oe,
  input  logic [NR_BUS-1:0] mdio_i
);

  localparam logic [BW:0]  NB       = (BW + 1)'(NR_BUS);
  localparam logic [4:0]   PRE_LAST = (PREAMBLE > 0) ? 5'(PREAMBLE - 1) : 5'd0;

  state_e              state_q, state_d;
  logic [4:0]          bit_q, bit_d;
  logic [BW-1:0]       bus_q;
  logic                rd_q, noresp_q, rej_q;
  logic [31:0]         tx_q;
  logic [DATA_W-1:0]   sh_q, md_q, rdata;
  logic [NR_BUS-1:0]   sy1_q, sy2_q;
  logic                accept, illegal, start, done, smp;
  logic                mdc_lvl, rise, fall, busy, run, oe, out_bit;

  assign accept  = s_dv && s_dr;
  assign illegal = !legal_op(s_c45, s_op) || (s_c45 && !C45_EN) || ({1'b0, s_bus} >= NB);
  assign start   = accept && !illegal;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk       (clk),
    .rst       (rst),
    .restart_i (start),
    .mdc_lvl_o (mdc_lvl),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q + 5'd1;
    if (!fall) bit_d = bit_q;
    if (fall) begin
      unique case (state_q)
        S_PRE:  if (bit_q == PRE_LAST)         begin state_d = S_HDR;  bit_d = '0; end
        S_HDR:  if (bit_q == 5'(HDR_W - 1))    begin state_d = S_TA;   bit_d = '0; end
        S_TA:   if (bit_q == 5'(TA_W - 1))     begin state_d = S_DATA; bit_d = '0; end
        S_DATA: if (bit_q == 5'(DATA_W - 1))   begin state_d = S_END;  bit_d = '0; end
        S_END:  begin state_d = S_IDLE; bit_d = '0; end
        default: bit_d = '0;
      endcase
    end
    if (start) begin
      state_d = (PREAMBLE > 0) ? S_PRE : S_HDR;
      bit_d   = '0;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign run     = busy && (state_q != S_END);
  // Reads release the line from the first turnaround bit onward
  assign oe      = (state_q == S_PRE) || (state_q == S_HDR) ||
                   (((state_q == S_TA) || (state_q == S_DATA)) && !rd_q);
  assign out_bit = !oe || (state_q == S_PRE) || tx_q[31];
  assign done    = (state_q == S_END) && fall;
  assign s_dr    = !busy || done;
  assign smp     = sy2_q[bus_q];
  assign rdata   = noresp_q ? '1 : sh_q;
  assign m_dv    = done && rd_q;
  assign m_d     = m_dv ? rdata : md_q;
  assign m_err   = rej_q || (m_dv && noresp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      bus_q    <= '0;
      rd_q     <= 1'b0;
      noresp_q <= 1'b0;
      rej_q    <= 1'b0;
      tx_q     <= '1;
      sh_q     <= '0;
      md_q     <= '0;
      sy1_q    <= '1;
      sy2_q    <= '1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rej_q   <= accept && illegal;
      sy1_q   <= mdio_i;
      sy2_q   <= sy1_q;
      if (start) begin
        bus_q    <= s_bus;
        rd_q     <= is_read(s_c45, s_op);
        noresp_q <= 1'b0;
        tx_q     <= {s_c45 ? ST_C45 : ST_C22, s_op, s_pa, s_ra,
                     is_read(s_c45, s_op) ? 2'b11 : TA_WR, s_d};
      end else if (fall && run && state_q != S_PRE) begin
        tx_q <= {tx_q[30:0], 1'b1};
      end
      if (rise && state_q == S_TA && bit_q == 5'(TA_W - 1)) noresp_q <= smp;
      if (rise && state_q == S_DATA) sh_q <= {sh_q[DATA_W-2:0], smp};
      if (m_dv) md_q <= rdata;
    end
  end

  for (genvar b = 0; b < NR_BUS; b++) begin : g_bus
    logic sel;
    assign sel        = busy && (bus_q == BW'(b));
    assign mdc[b]     = sel && run && mdc_lvl;
    assign mdio_oe[b] = sel && oe;
    assign mdio_o[b]  = !sel || out_bit;
  end

endmodule
